// File: rtl/multi_zone_monitor.sv
// Multi-zone temperature/presence/ignition monitor: snapshots N zones on a strobe and
// evaluates one zone per clock, driving hysteretic fans, debounced alarms and a hottest-zone report.
module multi_zone_monitor #(
  parameter int unsigned N_ZONES = 4,
  parameter int unsigned IW      = (N_ZONES > 1) ? $clog2(N_ZONES) : 1,
  parameter int unsigned TEMP_W  = 5,
  parameter int unsigned T_VENT  = 20,
  parameter int unsigned HYST    = 2,
  parameter int unsigned T_ALARM = 28,
  parameter int unsigned CONFIRM = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      datos_listos,
  input  logic [N_ZONES*TEMP_W-1:0] temperatura,
  input  logic [N_ZONES-1:0]        presencia,
  input  logic [N_ZONES-1:0]        ignicion,
  output logic [N_ZONES-1:0]        ventilacion,
  output logic [N_ZONES-1:0]        zona_alarma,
  output logic                      alarma,
  output logic [1:0]                estado,
  output logic [TEMP_W-1:0]         temp_max,
  output logic [IW-1:0]             zona_max,
  output logic                      dato_perdido
);

  localparam int unsigned CW = $clog2(CONFIRM + 1);
  localparam logic [TEMP_W-1:0] TOn     = TEMP_W'(T_VENT);
  localparam logic [TEMP_W-1:0] TOff    = TEMP_W'(T_VENT - HYST);
  localparam logic [TEMP_W-1:0] TAlarm  = TEMP_W'(T_ALARM);
  localparam logic [CW-1:0]     CntMax  = CW'(CONFIRM);
  localparam logic [IW-1:0]     LastIdx = IW'(N_ZONES - 1);

  typedef enum logic [1:0] {
    StEspera  = 2'b00,
    StLeer    = 2'b01,
    StDecidir = 2'b10,
    StAlerta  = 2'b11
  } state_e;

  state_e                          state_q, state_d;
  logic [IW-1:0]                   idx_q, idx_d;
  logic [N_ZONES*TEMP_W-1:0]       temp_snap_q, temp_snap_d;
  logic [N_ZONES-1:0]              pres_snap_q, pres_snap_d;
  logic [N_ZONES-1:0]              ign_snap_q, ign_snap_d;
  logic [N_ZONES-1:0][CW-1:0]      cnt_q, cnt_d;
  logic [N_ZONES-1:0]              vent_q, vent_d;
  logic [N_ZONES-1:0]              zal_q, zal_d;
  logic                            alarma_q, alarma_d;
  logic [TEMP_W-1:0]               max_temp_q, max_temp_d;
  logic [IW-1:0]                   max_idx_q, max_idx_d;
  logic [TEMP_W-1:0]               temp_max_q, temp_max_d;
  logic [IW-1:0]                   zona_max_q, zona_max_d;
  logic                            lost_q, lost_d;

  logic [TEMP_W-1:0] cur_temp;
  logic              peligro;
  logic [CW-1:0]     cnt_new;
  logic              new_max;

  assign cur_temp = temp_snap_q[int'(idx_q)*TEMP_W +: TEMP_W];
  assign peligro  = (cur_temp >= TAlarm) | (ign_snap_q[idx_q] & ~pres_snap_q[idx_q]);
  assign cnt_new  = !peligro ? '0 :
                    (cnt_q[idx_q] == CntMax) ? CntMax : cnt_q[idx_q] + 1'b1;
  // Tracker restarts on zone 0; strict compare keeps the lowest index on ties.
  assign new_max  = (idx_q == '0) || (cur_temp > max_temp_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    temp_snap_d = temp_snap_q;
    pres_snap_d = pres_snap_q;
    ign_snap_d  = ign_snap_q;
    cnt_d       = cnt_q;
    vent_d      = vent_q;
    zal_d       = zal_q;
    alarma_d    = alarma_q;
    max_temp_d  = max_temp_q;
    max_idx_d   = max_idx_q;
    temp_max_d  = temp_max_q;
    zona_max_d  = zona_max_q;
    lost_d      = 1'b0;

    case (state_q)
      StEspera, StAlerta: begin
        if (datos_listos) begin
          temp_snap_d = temperatura;
          pres_snap_d = presencia;
          ign_snap_d  = ignicion;
          state_d     = StLeer;
        end
      end
      StLeer: begin
        lost_d  = datos_listos;
        idx_d   = '0;
        state_d = StDecidir;
      end
      StDecidir: begin
        lost_d = datos_listos;
        if (cur_temp >= TOn) begin
          vent_d[idx_q] = 1'b1;
        end else if (cur_temp < TOff) begin
          vent_d[idx_q] = 1'b0;
        end
        cnt_d[idx_q] = cnt_new;
        zal_d[idx_q] = (cnt_new == CntMax);
        if (new_max) begin
          max_temp_d = cur_temp;
          max_idx_d  = idx_q;
        end
        if (idx_q == LastIdx) begin
          alarma_d   = |zal_d;
          temp_max_d = max_temp_d;
          zona_max_d = max_idx_d;
          idx_d      = '0;
          state_d    = alarma_d ? StAlerta : StEspera;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StEspera;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEspera;
      idx_q       <= '0;
      temp_snap_q <= '0;
      pres_snap_q <= '0;
      ign_snap_q  <= '0;
      cnt_q       <= '0;
      vent_q      <= '0;
      zal_q       <= '0;
      alarma_q    <= 1'b0;
      max_temp_q  <= '0;
      max_idx_q   <= '0;
      temp_max_q  <= '0;
      zona_max_q  <= '0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      temp_snap_q <= temp_snap_d;
      pres_snap_q <= pres_snap_d;
      ign_snap_q  <= ign_snap_d;
      cnt_q       <= cnt_d;
      vent_q      <= vent_d;
      zal_q       <= zal_d;
      alarma_q    <= alarma_d;
      max_temp_q  <= max_temp_d;
      max_idx_q   <= max_idx_d;
      temp_max_q  <= temp_max_d;
      zona_max_q  <= zona_max_d;
      lost_q      <= lost_d;
    end
  end

  assign ventilacion  = vent_q;
  assign zona_alarma  = zal_q;
  assign alarma       = alarma_q;
  assign estado       = state_q;
  assign temp_max     = temp_max_q;
  assign zona_max     = zona_max_q;
  assign dato_perdido = lost_q;

endmodule

// File: tb/tb_multi_zone_monitor.sv
// Bench for multi_zone_monitor: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a pass-level reference model.
module tb_multi_zone_monitor;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int IW = 2;
  localparam int TV = 20;
  localparam int HY = 2;
  localparam int TA = 28;
  localparam int CF = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           dl;
  logic [N*W-1:0] temperatura;
  logic [N-1:0]   presencia;
  logic [N-1:0]   ignicion;
  logic [N-1:0]   ventilacion;
  logic [N-1:0]   zona_alarma;
  logic           alarma;
  logic [1:0]     estado;
  logic [W-1:0]   temp_max;
  logic [IW-1:0]  zona_max;
  logic           dato_perdido;

  multi_zone_monitor #(
    .N_ZONES(N), .IW(IW), .TEMP_W(W), .T_VENT(TV), .HYST(HY), .T_ALARM(TA), .CONFIRM(CF)
  ) dut (
    .clk(clk), .rst(rst), .datos_listos(dl), .temperatura(temperatura),
    .presencia(presencia), .ignicion(ignicion), .ventilacion(ventilacion),
    .zona_alarma(zona_alarma), .alarma(alarma), .estado(estado), .temp_max(temp_max),
    .zona_max(zona_max), .dato_perdido(dato_perdido)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a pass is a captured snapshot plus an age in cycles since capture.
  int m_vent[N], m_cnt[N], m_zal[N], s_t[N];
  bit s_p[N], s_i[N];
  int m_alarma, m_tmax, m_zmax, m_lost, m_estado, m_age;
  bit m_busy;
  bit started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  z, best;
    bit  danger, any;
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        m_vent[j] = 0; m_cnt[j] = 0; m_zal[j] = 0;
      end
      m_alarma = 0; m_tmax = 0; m_zmax = 0; m_lost = 0; m_estado = 0; m_busy = 0; m_age = 0;
    end else begin
      m_lost = (dl && m_busy) ? 1 : 0;
      if (m_busy) begin
        m_age++;
        if (m_age == 1) begin
          m_estado = 2;
        end else begin
          z = m_age - 2;
          danger = (s_t[z] >= TA) || (s_i[z] && !s_p[z]);
          if (s_t[z] >= TV) m_vent[z] = 1;
          else if (s_t[z] < TV - HY) m_vent[z] = 0;
          m_cnt[z] = !danger ? 0 : (m_cnt[z] + 1 > CF ? CF : m_cnt[z] + 1);
          m_zal[z] = (m_cnt[z] == CF) ? 1 : 0;
          if (z == N - 1) begin
            any = 0;
            best = 0;
            for (int j = 0; j < N; j++) if (m_zal[j] != 0) any = 1;
            for (int j = 1; j < N; j++) if (s_t[j] > s_t[best]) best = j;
            m_alarma = any;
            m_tmax = s_t[best];
            m_zmax = best;
            m_estado = any ? 3 : 0;
            m_busy = 0;
          end
        end
      end else if (dl) begin
        for (int j = 0; j < N; j++) begin
          s_t[j] = int'(temperatura[j*W +: W]);
          s_p[j] = presencia[j];
          s_i[j] = ignicion[j];
        end
        m_busy = 1; m_age = 0; m_estado = 1;
      end
    end
    started = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [N-1:0] ev, ez;
    if (started) begin
      for (int j = 0; j < N; j++) begin
        ev[j] = (m_vent[j] != 0);
        ez[j] = (m_zal[j] != 0);
      end
      chk("ventilacion", int'(ventilacion), int'(ev));
      chk("zona_alarma", int'(zona_alarma), int'(ez));
      chk("alarma", int'(alarma), m_alarma);
      chk("estado", int'(estado), m_estado);
      chk("temp_max", int'(temp_max), m_tmax);
      chk("zona_max", int'(zona_max), m_zmax);
      chk("dato_perdido", int'(dato_perdido), m_lost);
    end
  end

  task automatic step(input bit r, input bit d);
    rst = r;
    dl  = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input int t0, t1, t2, t3, input logic [N-1:0] p, i);
    temperatura = {W'(t3), W'(t2), W'(t1), W'(t0)};
    presencia   = p;
    ignicion    = i;
  endtask

  task automatic run_pass();
    step(1'b0, 1'b1);
    repeat (N + 1) step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    dl  = 1'b0;
    set_in(15, 15, 15, 15, 4'hF, 4'h0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    chk("idle_estado", int'(estado), 0);
    chk("idle_vent", int'(ventilacion), 0);
    chk("idle_alarma", int'(alarma), 0);

    // Hysteresis on zone 1
    set_in(15, 21, 15, 15, 4'hF, 4'h0); run_pass();
    chk("hyst_21", int'(ventilacion), 4'b0010);
    set_in(15, 19, 15, 15, 4'hF, 4'h0); run_pass();
    chk("hyst_19", int'(ventilacion), 4'b0010);
    set_in(15, 17, 15, 15, 4'hF, 4'h0); run_pass();
    chk("hyst_17", int'(ventilacion), 4'b0000);

    // Debounce on zone 2
    set_in(15, 15, 30, 15, 4'hF, 4'h0);
    run_pass();
    chk("deb1_zal", int'(zona_alarma), 0);
    chk("deb1_estado", int'(estado), 0);
    run_pass();
    chk("deb2_zal", int'(zona_alarma), 0);
    chk("deb2_estado", int'(estado), 0);
    step(1'b0, 1'b1);
    repeat (N) step(1'b0, 1'b0);
    chk("deb3_busy_estado", int'(estado), 2);
    step(1'b0, 1'b0);
    chk("deb3_estado", int'(estado), 3);
    chk("deb3_zal", int'(zona_alarma), 4'b0100);
    chk("deb3_alarma", int'(alarma), 1);
    set_in(15, 15, 25, 15, 4'hF, 4'h0); run_pass();
    chk("deb_clear_alarma", int'(alarma), 0);
    chk("deb_clear_estado", int'(estado), 0);

    // Ignition without presence on zone 0
    set_in(15, 15, 15, 15, 4'b1110, 4'b0001);
    run_pass(); run_pass();
    chk("ign2_alarma", int'(alarma), 0);
    run_pass();
    chk("ign3_alarma", int'(alarma), 1);
    chk("ign3_zal", int'(zona_alarma), 4'b0001);
    set_in(15, 15, 15, 15, 4'hF, 4'b0001); run_pass();
    chk("ign_pres_alarma", int'(alarma), 0);
    chk("ign_pres_zal", int'(zona_alarma), 0);

    // Max tie keeps the lowest index
    set_in(22, 27, 27, 10, 4'hF, 4'h0); run_pass();
    chk("tie_temp_max", int'(temp_max), 27);
    chk("tie_zona_max", int'(zona_max), 1);

    // Strobe while busy
    set_in(5, 9, 30, 9, 4'hF, 4'h0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("busy_lost_pulse", int'(dato_perdido), 1);
    step(1'b0, 1'b0);
    chk("busy_lost_clear", int'(dato_perdido), 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("busy_temp_max", int'(temp_max), 30);
    chk("busy_zona_max", int'(zona_max), 2);

    // Reset in the middle of a pass
    set_in(22, 27, 27, 10, 4'hF, 4'h0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_vent", int'(ventilacion), 0);
    chk("rst_estado", int'(estado), 0);
    chk("rst_temp_max", int'(temp_max), 0);
    step(1'b0, 1'b0);

    // Randomized traffic
    repeat (600) begin
      set_in($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), N'($urandom), N'($urandom));
      step($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);
    end
    repeat (N + 3) step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_zone_monitor.md
# multi_zone_monitor

Parametrised multi-zone successor to the single-zone temperature/presence/ignition controller. It samples N zones on a data-ready strobe and evaluates them one zone per clock in a read/decide/alert state machine. Per zone it drives ventilation with hysteresis and a debounced alarm; it also reports the hottest zone. It sits between the sensor-synchronisation stage and the display/BCD path, replacing the single-zone activation logic and control FSM.

## Interface
Parameters:
- N_ZONES, 4, number of zones (≥1); IW = max(1, $clog2(N_ZONES))
- TEMP_W, 5, temperature width, unsigned
- T_VENT, 20, ventilation turn-on threshold (°C)
- HYST, 2, ventilation hysteresis; off when temp < T_VENT−HYST; requires HYST < T_VENT
- T_ALARM, 28, over-temperature threshold
- CONFIRM, 3, consecutive dangerous samples before a zone alarms (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- datos_listos  in  1  sample strobe, level-sampled each cycle
- temperatura  in  N_ZONES*TEMP_W  zone z at bits [z*TEMP_W +: TEMP_W]
- presencia  in  N_ZONES  occupant present per zone
- ignicion  in  N_ZONES  ignition active per zone
- ventilacion  out  N_ZONES  per-zone fan enable
- zona_alarma  out  N_ZONES  per-zone confirmed alarm
- alarma  out  1  OR of zona_alarma, registered at end of pass
- estado  out  2  FSM state code, for the 7-segment state digit
- temp_max  out  TEMP_W  highest temperature of last completed pass
- zona_max  out  IW  index of temp_max zone
- dato_perdido  out  1  one-cycle pulse: strobe ignored while busy

## Operation
- States: ESPERA=00, LEER=01, DECIDIR=10, ALERTA=11.
- ESPERA/ALERTA + datos_listos=1:
  - snapshot temperatura, presencia and ignicion into internal registers;
  - go to LEER.
- LEER: one cycle, then go to DECIDIR with idx=0.
- DECIDIR: each cycle processes zone idx from the snapshot, then idx++.
  - Ventilation:
    - temp ≥ T_VENT → ventilacion[idx]=1;
    - temp < T_VENT−HYST → 0;
    - otherwise hold.
  - peligro_z = (temp ≥ T_ALARM) | (ignicion & ~presencia).
  - Per-zone counter cnt:
    - peligro_z → cnt = min(cnt+1, CONFIRM) (saturating);
    - else cnt=0.
    - zona_alarma[idx] = (new cnt == CONFIRM).
  - Max tracker: a running max over the pass. Strictly greater replaces, so ties keep the lowest index.
  - At idx=N_ZONES−1:
    - alarma ← OR of updated zona_alarma;
    - temp_max/zona_max ← tracker;
    - go to ALERTA if alarma else ESPERA.
- ALERTA: alarma held. Only a new pass can clear it.
- datos_listos=1 in LEER or DECIDIR: ignored, dato_perdido=1 the next cycle. The pass continues unaffected.
- Arithmetic: compares are unsigned at TEMP_W. Thresholds are truncated to TEMP_W. The counter is $clog2(CONFIRM+1) bits.

## Timing
- Reset (sync): estado=00, idx=0, all counters 0. ventilacion, zona_alarma, alarma, temp_max, zona_max and dato_perdido are all 0.
- Strobe sampled at edge k → estado=LEER after k.
  - Zone z is updated at edge k+2+z.
  - alarma, temp_max and the final state are valid after edge k+1+N_ZONES.
  - Total latency is N_ZONES+2 cycles (6 at default).
- Strobe on the same edge as the pass-ending transition is ignored, because the state is still DECIDIR. Back-to-back passes need a strobe at least one cycle after completion.
- Mid-pass reset: everything returns to reset values on that edge. The partial pass is discarded.
- Inputs are used only through the snapshot; changes after the capture edge have no effect on the pass.

## Test plan
- Reset then idle: all temps 15, no strobe → all outputs 0, estado=00 indefinitely.
- Hysteresis, zone 1: strobes with temps 21, 19, 17 → ventilacion[1] is 1, 1, 0. Other zones stay 0.
- Debounce, zone 2 at temp 30:
  - first two passes → zona_alarma[2]=0, estado=00;
  - third pass → zona_alarma[2]=1, alarma=1, estado=11 exactly 6 cycles after the strobe;
  - next pass at 25 → alarma=0, estado=00.
- Ignition without presence: zone 0 ign=1, pres=0, CONFIRM passes → alarma=1. With pres=1 the counter resets and no alarm is raised.
- Max tie: temps {22, 27, 27, 10} → temp_max=27, zona_max=1.
- Busy strobe: strobe again 2 cycles after the first → one dato_perdido pulse, pass result unchanged. Reset asserted mid-DECIDIR → all outputs 0 next cycle.
